// File: rtl/cozy_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cozy_mem_arbiter
// Description : Two-port (CPU / video-DMA) arbiter for cozy_memory with a
//               bounded CPU burst and a fixed two-cycle read-return pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module cozy_mem_arbiter #(
    parameter int BURST_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        a_req,
    input  logic [15:0] a_addr,
    input  logic [15:0] a_wdata,
    input  logic [1:0]  a_bwe,
    output logic        a_gnt,
    output logic        a_rvalid,
    output logic [15:0] a_rdata,

    input  logic        b_req,
    input  logic [15:0] b_addr,
    input  logic [15:0] b_wdata,
    input  logic [1:0]  b_bwe,
    output logic        b_gnt,
    output logic        b_rvalid,
    output logic [15:0] b_rdata,

    output logic [15:0] mem_addr,
    output logic [15:0] mem_din,
    output logic [1:0]  mem_bwe,
    input  logic [15:0] mem_dout
);

    localparam int              c_CW    = (BURST_LIMIT < 1) ? 1 : $clog2(BURST_LIMIT + 1);
    localparam logic [c_CW-1:0] c_LIMIT = c_CW'(BURST_LIMIT);

    logic [c_CW-1:0] r_burst;
    logic            r_rd_pend;
    logic            r_rd_port;
    logic            r_rv_a;
    logic            r_rv_b;

    logic            w_at_limit;
    logic            w_a_gnt;
    logic            w_b_gnt;
    logic            w_accept;
    logic [15:0]     w_addr;
    logic [15:0]     w_wdata;
    logic [1:0]      w_bwe;

    // Grants are gated by rst_n so nothing is accepted while reset is held.
    assign w_at_limit = (r_burst == c_LIMIT);
    assign w_a_gnt    = rst_n & a_req & (~b_req | ~w_at_limit);
    assign w_b_gnt    = rst_n & b_req & ~w_a_gnt;
    assign w_accept   = w_a_gnt | w_b_gnt;

    assign w_addr  = w_b_gnt ? b_addr  : a_addr;
    assign w_wdata = w_b_gnt ? b_wdata : a_wdata;
    assign w_bwe   = w_b_gnt ? b_bwe   : a_bwe;

    assign a_gnt    = w_a_gnt;
    assign b_gnt    = w_b_gnt;
    assign a_rvalid = r_rv_a;
    assign b_rvalid = r_rv_b;
    assign a_rdata  = mem_dout;
    assign b_rdata  = mem_dout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_burst <= '0;
        end else if (!b_req || w_b_gnt) begin
            r_burst <= '0;
        end else if (w_a_gnt && !w_at_limit) begin
            r_burst <= r_burst + c_CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr <= 16'h0000;
            mem_din  <= 16'h0000;
            mem_bwe  <= 2'b00;
        end else if (w_accept) begin
            mem_addr <= w_addr;
            mem_din  <= w_wdata;
            mem_bwe  <= w_bwe;
        end else begin
            mem_bwe  <= 2'b00;
        end
    end

    // Read tag rides one stage while the memory fetches, then becomes rvalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_pend <= 1'b0;
            r_rd_port <= 1'b0;
            r_rv_a    <= 1'b0;
            r_rv_b    <= 1'b0;
        end else begin
            r_rd_pend <= w_accept & (w_bwe == 2'b00);
            r_rd_port <= w_b_gnt;
            r_rv_a    <= r_rd_pend & ~r_rd_port;
            r_rv_b    <= r_rd_pend &  r_rd_port;
        end
    end

endmodule
`default_nettype wire
